// File: rtl/xfer_fsm_param_if.sv
// Bundles the sequencer's control, source-read and destination-write signals.
// master: the sequencer; slave: the host/memories side.
interface xfer_fsm_param_if #(
  parameter int SRC_AW = 16,
  parameter int DST_AW = 8,
  parameter int DST_DW = 8,
  parameter int SRC_DW = 16,
  parameter int LEN_W  = 8
);
  logic              enable;
  logic              start;
  logic              mode;
  logic [SRC_AW-1:0] src_base;
  logic [DST_AW-1:0] dst_base;
  logic [LEN_W-1:0]  xfer_len;
  logic [SRC_AW-1:0] src_addr;
  logic              src_rd;
  logic [SRC_DW-1:0] src_rdata;
  logic [DST_AW-1:0] dst_addr;
  logic [DST_DW-1:0] dst_wdata;
  logic              dst_we;
  logic              busy;
  logic              done;
  logic              abort;
  logic [LEN_W-1:0]  words_done;
  logic [2:0]        st_fsm_o;

  modport master (
    input  enable, start, mode, src_base, dst_base, xfer_len, src_rdata,
    output src_addr, src_rd, dst_addr, dst_wdata, dst_we,
           busy, done, abort, words_done, st_fsm_o
  );

  modport slave (
    output enable, start, mode, src_base, dst_base, xfer_len, src_rdata,
    input  src_addr, src_rd, dst_addr, dst_wdata, dst_we,
           busy, done, abort, words_done, st_fsm_o
  );
endinterface

// File: rtl/xfer_fsm_param.sv
// Word-copy sequencer: read one source word, capture it, write it to the destination (3 cycles/word).
// SPLIT mode takes {addr,data} from the word; LINEAR mode writes its low half at an incrementing address.
module xfer_fsm_param #(
  parameter int SRC_AW = 16,
  parameter int DST_AW = 8,
  parameter int DST_DW = 8,
  parameter int SRC_DW = 16,
  parameter int LEN_W  = 8
) (
  input logic             clk,
  input logic             rst,
  xfer_fsm_param_if.master bus
);

  generate
    if (SRC_DW != DST_AW + DST_DW) begin : g_bad_width
      $error("xfer_fsm_param: SRC_DW must equal DST_AW + DST_DW");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [SRC_AW-1:0] src_base_q, src_base_d;
  logic [DST_AW-1:0] dst_base_q, dst_base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wd_q, wd_d, wd_inc;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
  logic [DST_DW-1:0] dst_wdata_q, dst_wdata_d;
  logic              src_rd_q, src_rd_d;
  logic              dst_we_q, dst_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  assign wd_inc = wd_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    len_d       = len_q;
    wd_d        = wd_q;
    src_addr_d  = src_addr_q;
    dst_addr_d  = dst_addr_q;
    dst_wdata_d = dst_wdata_q;
    src_rd_d    = 1'b0;
    dst_we_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    // Outputs are computed for the state being entered, so they line up with it once registered.
    case (state_q)
      IDLE: begin
        if (bus.enable && bus.start) begin
          mode_d     = bus.mode;
          src_base_d = bus.src_base;
          dst_base_d = bus.dst_base;
          len_d      = bus.xfer_len;
          wd_d       = '0;
          if (bus.xfer_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = READ;
            src_rd_d   = 1'b1;
            busy_d     = 1'b1;
            src_addr_d = bus.src_base;
          end
        end
      end
      READ: begin
        if (!bus.enable) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = CAPT;
          busy_d  = 1'b1;
        end
      end
      CAPT: begin
        if (!bus.enable) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          state_d     = WRITE;
          busy_d      = 1'b1;
          dst_we_d    = 1'b1;
          dst_wdata_d = bus.src_rdata[DST_DW-1:0];
          dst_addr_d  = mode_q ? dst_base_q + DST_AW'(wd_q)
                               : bus.src_rdata[SRC_DW-1:DST_DW];
        end
      end
      WRITE: begin
        // The write strobed this cycle lands even if the transfer is aborted here.
        wd_d = wd_inc;
        if (!bus.enable) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (wd_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = READ;
          src_rd_d   = 1'b1;
          busy_d     = 1'b1;
          src_addr_d = src_base_q + SRC_AW'(wd_inc);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      wd_q        <= '0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
      src_rd_q    <= 1'b0;
      dst_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      len_q       <= len_d;
      wd_q        <= wd_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
      src_rd_q    <= src_rd_d;
      dst_we_q    <= dst_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.src_addr   = src_addr_q;
  assign bus.src_rd     = src_rd_q;
  assign bus.dst_addr   = dst_addr_q;
  assign bus.dst_wdata  = dst_wdata_q;
  assign bus.dst_we     = dst_we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.abort      = abort_q;
  assign bus.words_done = wd_q;
  assign bus.st_fsm_o   = state_q;

endmodule

// File: tb/tb_xfer_fsm_param.sv
// Bench for xfer_fsm_param: directed scenarios plus randomized transfers checked cycle by cycle
// against a schedule model (3 cycles per word, start cycle counted as cycle 1).
module tb_xfer_fsm_param;
  localparam int SRC_AW = 16;
  localparam int DST_AW = 8;
  localparam int DST_DW = 8;
  localparam int SRC_DW = 16;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xfer_fsm_param_if #(.SRC_AW(SRC_AW), .DST_AW(DST_AW), .DST_DW(DST_DW),
                      .SRC_DW(SRC_DW), .LEN_W(LEN_W)) bus ();

  xfer_fsm_param #(.SRC_AW(SRC_AW), .DST_AW(DST_AW), .DST_DW(DST_DW),
                   .SRC_DW(SRC_DW), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Source memory with one-cycle synchronous read.
  logic [15:0] smem [0:65535];
  always @(posedge clk) if (bus.src_rd) bus.src_rdata <= smem[bus.src_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [7:0] exp_wd);
    chk({tag, " src_rd"}, 32'(bus.src_rd), 0);
    chk({tag, " dst_we"}, 32'(bus.dst_we), 0);
    chk({tag, " busy"},   32'(bus.busy), 0);
    chk({tag, " done"},   32'(bus.done), 0);
    chk({tag, " abort"},  32'(bus.abort), 0);
    chk({tag, " state"},  32'(bus.st_fsm_o), 0);
    chk({tag, " words"},  32'(bus.words_done), 32'(exp_wd));
  endtask

  task automatic fill(input logic [15:0] sb, input int len);
    for (int i = 0; i < len; i++) smem[sb + 16'(i)] = 16'($urandom);
  endtask

  // One transfer. ab: cycle whose end sees enable low (0 = none). pk: cycle with a stray start (0 = none).
  task automatic run_xfer(input string name, input logic m, input logic [15:0] sb,
                          input logic [7:0] db, input int len, input int ab, input int pk);
    int last, i, p, pkk;
    logic e_rd, e_we, e_busy, e_done, e_abort;
    logic [2:0]  e_st;
    logic [7:0]  e_wd, e_daddr;
    logic [15:0] w, e_saddr;
    string tg;
    pkk = (ab > 0 && pk >= ab) ? 0 : pk;
    @(negedge clk);
    bus.enable = 1'b1; bus.mode = m; bus.src_base = sb; bus.dst_base = db;
    bus.xfer_len = 8'(len); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // Latched parameters must not follow the live inputs.
    bus.mode = ~m; bus.src_base = 16'($urandom); bus.dst_base = 8'($urandom); bus.xfer_len = 8'($urandom);
    last = 3 * len + 3;
    for (int n = 1; n <= last; n++) begin
      e_rd = 0; e_we = 0; e_busy = 0; e_done = 0; e_abort = 0; e_st = 0;
      e_saddr = 0; e_daddr = 0; w = 0;
      i = (n - 1) / 3; p = (n - 1) % 3;
      if (ab > 0 && n > ab) begin
        e_abort = (n == ab + 1);
        e_wd = 8'(ab / 3);
      end else if (len == 0) begin
        e_done = (n == 1); e_st = (n == 1) ? 3'd4 : 3'd0; e_wd = 0;
      end else if (n <= 3 * len) begin
        e_busy = 1; e_st = 3'(p + 1); e_wd = 8'(i);
        e_saddr = sb + 16'(i);
        w = smem[e_saddr];
        e_daddr = m ? db + 8'(i) : w[15:8];
        e_rd = (p == 0); e_we = (p == 2);
      end else begin
        e_done = (n == 3 * len + 1); e_st = e_done ? 3'd4 : 3'd0; e_wd = 8'(len);
      end
      tg = $sformatf("%s c%0d", name, n + 1);
      chk({tg, " src_rd"}, 32'(bus.src_rd), 32'(e_rd));
      chk({tg, " dst_we"}, 32'(bus.dst_we), 32'(e_we));
      chk({tg, " busy"},   32'(bus.busy),   32'(e_busy));
      chk({tg, " done"},   32'(bus.done),   32'(e_done));
      chk({tg, " abort"},  32'(bus.abort),  32'(e_abort));
      chk({tg, " state"},  32'(bus.st_fsm_o), 32'(e_st));
      chk({tg, " words"},  32'(bus.words_done), 32'(e_wd));
      if (e_rd) chk({tg, " src_addr"}, 32'(bus.src_addr), 32'(e_saddr));
      if (e_we) begin
        chk({tg, " dst_addr"},  32'(bus.dst_addr),  32'(e_daddr));
        chk({tg, " dst_wdata"}, 32'(bus.dst_wdata), 32'(w[7:0]));
      end
      bus.enable = (n != ab);
      bus.start  = (n == pkk);
      @(negedge clk);
    end
    bus.enable = 1'b1;
    bus.start  = 1'b0;
  endtask

  initial begin
    logic [15:0] sb;
    logic [7:0]  db;
    int len, ab, pk;
    logic m;

    rst = 1'b1;
    bus.enable = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
    bus.src_base = '0; bus.dst_base = '0; bus.xfer_len = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset", 8'd0);
    chk("reset src_addr",  32'(bus.src_addr), 0);
    chk("reset dst_addr",  32'(bus.dst_addr), 0);
    chk("reset dst_wdata", 32'(bus.dst_wdata), 0);
    rst = 1'b0;

    // start with enable low is not accepted
    bus.xfer_len = 8'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk_quiet("start_no_enable", 8'd0);
    bus.enable = 1'b1;

    smem[16'h0010] = 16'h2A55; smem[16'h0011] = 16'h2B66; smem[16'h0012] = 16'h07FF;
    run_xfer("split3", 1'b0, 16'h0010, 8'h00, 3, 0, 0);

    smem[16'h0200] = 16'h1234; smem[16'h0201] = 16'hABCD;
    run_xfer("lin2_wrap", 1'b1, 16'h0200, 8'hFF, 2, 0, 0);

    run_xfer("zero_len", 1'b0, 16'h0300, 8'h00, 0, 0, 0);

    fill(16'h0400, 4);
    run_xfer("abort", 1'b0, 16'h0400, 8'h00, 4, 7, 0);

    // reset while in CAPT of the first word
    fill(16'h0500, 4);
    @(negedge clk);
    bus.src_base = 16'h0500; bus.xfer_len = 8'd4; bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid in CAPT", 32'(bus.st_fsm_o), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("rst_mid", 8'd0);
    chk("rst_mid src_addr",  32'(bus.src_addr), 0);
    chk("rst_mid dst_addr",  32'(bus.dst_addr), 0);
    chk("rst_mid dst_wdata", 32'(bus.dst_wdata), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_quiet($sformatf("rst_after c%0d", k), 8'd0);
    end
    run_xfer("after_rst", 1'b0, 16'h0500, 8'h00, 4, 0, 0);

    smem[16'hFFFF] = 16'h5AA5; smem[16'h0000] = 16'hC33C;
    run_xfer("src_wrap", 1'b0, 16'hFFFF, 8'h00, 2, 0, 4);

    fill(16'h1000, 255);
    run_xfer("len255", 1'b1, 16'h1000, 8'h80, 255, 0, 0);

    for (int t = 0; t < 24; t++) begin
      m   = 1'($urandom_range(0, 1));
      sb  = 16'($urandom);
      db  = 8'($urandom);
      len = $urandom_range(0, 7);
      fill(sb, len);
      ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * len) : 0;
      pk  = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 3 * len + 1) : 0;
      run_xfer($sformatf("rand%0d", t), m, sb, db, len, ab, pk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xfer_fsm_param.md
Name: xfer_fsm_param

Overview:
- Parametrised transfer sequencer that replaces the fixed 16-bit-to-8-bit copy engine.
- Reads a block of words from a source memory with synchronous read, and builds a destination write for each word.
- Each destination write is an {address, data} pair taken from the word (SPLIT mode), or a word written at an incrementing destination address (LINEAR mode).
- Sits between the wide source memory and the narrow destination memory. Control comes from the testbench or host via a start/busy/done handshake.

Parameters:
- SRC_AW, 16, source memory address width.
- DST_AW, 8, destination memory address width.
- DST_DW, 8, destination memory data width.
- SRC_DW, 16, source word width. Must equal DST_AW+DST_DW; otherwise elaboration fails via a static check.
- LEN_W, 8, width of the transfer-length and progress counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  global enable; low aborts any transfer to IDLE on the next edge.
- start  in  1  single-cycle request; sampled only in IDLE with enable high.
- mode  in  1  0=SPLIT, 1=LINEAR; latched at start.
- src_base  in  SRC_AW  first source address; latched at start.
- dst_base  in  DST_AW  LINEAR-mode first destination address; latched at start.
- xfer_len  in  LEN_W  number of words to move; latched at start.
- src_addr  out  SRC_AW  source read address.
- src_rd  out  1  source read strobe; data returns one cycle later.
- src_rdata  in  SRC_DW  source read data.
- dst_addr  out  DST_AW  destination write address.
- dst_wdata  out  DST_DW  destination write data.
- dst_we  out  1  destination write strobe, one cycle per word.
- busy  out  1  high in READ, CAPT and WRITE.
- done  out  1  one-cycle pulse on completion.
- abort  out  1  one-cycle pulse when enable drops while busy.
- words_done  out  LEN_W  count of words written in the current or last transfer.
- st_fsm_o  out  3  current state encoding, for the bench.

Behaviour:
- State encoding: IDLE=0, READ=1, CAPT=2, WRITE=3, DONE=4. All outputs are registered.
- Reset (rst=1 at an edge) forces:
  - state IDLE;
  - src_rd, dst_we, busy, done and abort all 0;
  - src_addr, dst_addr, dst_wdata and words_done all 0.
- Reset takes priority over enable and start, including mid-transfer; any transfer in progress is dropped with no done or abort pulse.
- IDLE:
  - On start=1 and enable=1, latch mode, src_base, dst_base and xfer_len, and clear words_done.
  - If xfer_len=0, go to DONE. Otherwise go to READ.
  - start while busy is ignored.
- READ: src_rd=1 for exactly this cycle; src_addr = src_base+words_done, wrapping modulo 2^SRC_AW. Next state CAPT.
- CAPT: register src_rdata.
  - SPLIT: dst_addr = rdata[SRC_DW-1:DST_DW], dst_wdata = rdata[DST_DW-1:0].
  - LINEAR: dst_addr = dst_base+words_done, wrapping modulo 2^DST_AW; dst_wdata = rdata[DST_DW-1:0].
  - Next state WRITE.
- WRITE:
  - dst_we=1 for exactly this cycle, and words_done increments.
  - If the incremented count equals xfer_len, go to DONE. Otherwise go to READ.
- DONE: done=1 for one cycle, then IDLE. words_done holds its final value until the next start.
- Throughput is 3 cycles per word. Latency from the start edge to the done pulse is 3*xfer_len+2 cycles; xfer_len=0 gives done 2 cycles after start.
- Abort on enable=0 in READ, CAPT or WRITE:
  - Next edge goes to IDLE, pulses abort, and drops src_rd, dst_we and busy.
  - words_done keeps its partial value.
  - A write already asserted in the abort cycle is not repeated.
- enable=0 in IDLE or DONE goes to IDLE without an abort pulse; a pending done pulse is suppressed.
- xfer_len = 2^LEN_W-1 is legal; the counter never overflows because it terminates at xfer_len.

Test Plan:
- SPLIT, 3 words: src_base=0x0010, xfer_len=3, source [0x10]=0x2A55, [0x11]=0x2B66, [0x12]=0x07FF -> dst writes (0x2A,0x55), (0x2B,0x66), (0x07,0xFF) on cycles 4, 7 and 10 after start; done on cycle 11; words_done=3.
- LINEAR, 2 words: mode=1, dst_base=0xFF, source words 0x1234 and 0xABCD -> dst writes (0xFF,0x34) then (0x00,0xCD), showing destination address wrap.
- Zero length: xfer_len=0 -> no src_rd and no dst_we; done pulses 2 cycles after start; busy never asserts.
- Abort: xfer_len=4, enable dropped during the READ of word 2 -> abort pulse; state 0 next cycle; words_done=2; no further dst_we.
- Reset mid-transfer: rst asserted in CAPT -> all outputs 0 and state 0 at the next edge, with no done or abort. A fresh start afterwards completes normally.
- Source wrap and ignored start: src_base=0xFFFF, xfer_len=2 -> reads at 0xFFFF then 0x0000. A start pulse mid-transfer has no effect.
